// File: rtl/byte_word_packer_pkg.sv
// Shared constants and helpers for the byte-to-word packer.
// Lane masks are built here so top and bench agree on keep encoding.
package byte_word_packer_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int MAX_BYTES          = 8;

    function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned count);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < count);
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_word_packer_out.sv
// One-entry valid/ready output register: load, hold while stalled, drain.
// Word and keep keep their last value after a drain; only valid drops.
module word_out_reg
    import byte_word_packer_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_word,
    input  logic [K-1:0] load_keep,
    input  logic         out_ready,
    output logic [W-1:0] out_word,
    output logic [K-1:0] out_keep,
    output logic         out_valid
);

    logic [W-1:0] word_q, word_d;
    logic [K-1:0] keep_q, keep_d;
    logic         valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        keep_d  = keep_q;
        valid_d = valid_q;
        if (load) begin
            word_d  = load_word;
            keep_d  = load_keep;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
        end
    end

    assign out_word  = word_q;
    assign out_keep  = keep_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/byte_word_packer.sv
// Packs a byte stream into words, first byte in lane 0, with keep mask.
// A flush emits the partial word; if the output is busy it waits pending.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int CNT_W          = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BYTE_W-1:0]                in_byte,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] out_word,
    output logic [BYTES_PER_WORD-1:0]        out_keep,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int         WW   = BYTE_W * BYTES_PER_WORD;
    localparam int         EW   = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);

    logic [WW-1:0]             acc_q, acc_d, acc_wr;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      flush_pend_q, flush_pend_d;
    logic                      accept, slot_free;
    logic [EW-1:0]             eff_cnt;
    logic                      load;
    logic [BYTES_PER_WORD-1:0] load_keep;

    // Registers only: keeps in_ready free of any input-to-output path.
    assign in_ready = !flush_pend_q && !(out_valid && cnt_q == LAST);

    always_comb begin
        accept    = in_valid && in_ready;
        slot_free = !out_valid || out_ready;
        acc_wr    = acc_q;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (accept && CNT_W'(k) == cnt_q) begin
                acc_wr[k*BYTE_W +: BYTE_W] = in_byte;
            end
        end
        eff_cnt   = {1'b0, cnt_q} + EW'(accept);
        load_keep = BYTES_PER_WORD'(keep_mask(32'(eff_cnt)));

        acc_d        = acc_wr;
        cnt_d        = accept ? cnt_q + CNT_W'(1) : cnt_q;
        flush_pend_d = flush_pend_q;
        load         = 1'b0;

        // A completing byte wins over flush, so only one full word goes out.
        if (accept && cnt_q == LAST) begin
            load  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
        end else if (flush_pend_q) begin
            if (slot_free) begin
                load         = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
                flush_pend_d = 1'b0;
            end
        end else if (flush && eff_cnt != '0) begin
            if (slot_free) begin
                load  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    word_out_reg #(
        .W (WW),
        .K (BYTES_PER_WORD)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_word (acc_wr),
        .load_keep (load_keep),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_keep  (out_keep),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: vector table plus corner sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_word;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    byte_word_packer #(
        .BYTES_PER_WORD (4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_word  (out_word),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        v;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic [31:0] ew;
        logic [3:0]  ek;
        logic        eir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] b, logic v, logic fl, logic rdy,
                                logic ev, logic [31:0] ew, logic [3:0] ek,
                                logic eir);
        vec_t t;
        t.b = b; t.v = v; t.fl = fl; t.rdy = rdy;
        t.ev = ev; t.ew = ew; t.ek = ek; t.eir = eir;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(logic [7:0] b, logic v, logic fl, logic rdy);
        in_byte   = b;
        in_valid  = v;
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(string name, logic [31:0] w, logic [3:0] k);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".word"}, out_word, w);
        chk({name, ".keep"}, 32'(out_keep), 32'(k));
    endtask

    initial begin
        reset     = 1'b1;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Row format: inputs before the edge, expected outputs after it.
        tbl.push_back(mk(8'h17, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'h4B, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'h3C, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'h0F, 1, 0, 1, 1, 32'h0F3C4B17, 4'hF, 1));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'hA5, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'h5A, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'hDE, 0, 1, 1, 1, 32'h00005AA5, 4'h3, 1));
        tbl.push_back(mk(8'hC3, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'h00, 0, 1, 1, 1, 32'h000000C3, 4'h1, 1));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'hFF, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'hFF, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'hFF, 1, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'hFF, 1, 1, 1, 1, 32'hFFFFFFFF, 4'hF, 1));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 32'h0, 4'h0, 1));
        tbl.push_back(mk(8'hB7, 1, 1, 1, 1, 32'h000000B7, 4'h1, 1));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 32'h0, 4'h0, 1));

        #12;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.word", out_word, 32'h0);
        chk("rst.keep", 32'(out_keep), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) begin
            cyc(tbl[i].b, tbl[i].v, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d.word", i), out_word, tbl[i].ew);
                chk($sformatf("vec%0d.keep", i), 32'(out_keep), 32'(tbl[i].ek));
            end
        end

        // Backpressure: second word waits for the held first word.
        cyc(8'h11, 1, 0, 0);
        cyc(8'h22, 1, 0, 0);
        cyc(8'h33, 1, 0, 0);
        cyc(8'h44, 1, 0, 0);
        chk_word("bp.w0", 32'h44332211, 4'hF);
        cyc(8'h55, 1, 0, 0);
        cyc(8'h66, 1, 0, 0);
        cyc(8'h77, 1, 0, 0);
        chk("bp.in_ready_low", 32'(in_ready), 32'd0);
        chk_word("bp.w0_hold", 32'h44332211, 4'hF);
        cyc(8'h88, 1, 0, 0);
        chk_word("bp.w0_hold2", 32'h44332211, 4'hF);
        cyc(8'h88, 1, 0, 1);
        chk("bp.drain", 32'(out_valid), 32'd0);
        chk("bp.in_ready_back", 32'(in_ready), 32'd1);
        cyc(8'h88, 1, 0, 1);
        chk_word("bp.w1", 32'h88776655, 4'hF);
        cyc(8'h00, 0, 0, 1);
        chk("bp.w1_once", 32'(out_valid), 32'd0);

        // Flush while the output slot is busy.
        cyc(8'hA1, 1, 0, 0);
        cyc(8'hA2, 1, 0, 0);
        cyc(8'hA3, 1, 0, 0);
        cyc(8'hA4, 1, 0, 0);
        chk_word("fp.held", 32'hA4A3A2A1, 4'hF);
        cyc(8'h01, 1, 0, 0);
        cyc(8'h00, 0, 1, 0);
        chk("fp.in_ready_low", 32'(in_ready), 32'd0);
        cyc(8'h99, 1, 1, 0);
        chk("fp.still_low", 32'(in_ready), 32'd0);
        chk_word("fp.held2", 32'hA4A3A2A1, 4'hF);
        cyc(8'h00, 0, 0, 1);
        chk_word("fp.partial", 32'h00000001, 4'h1);
        chk("fp.in_ready_back", 32'(in_ready), 32'd1);
        cyc(8'h00, 0, 0, 1);
        chk("fp.once", 32'(out_valid), 32'd0);
        cyc(8'h00, 0, 1, 1);
        chk("fp.no_residue", 32'(out_valid), 32'd0);

        // Reset mid-word with a held output word.
        cyc(8'hE1, 1, 0, 0);
        cyc(8'hE2, 1, 0, 0);
        cyc(8'hE3, 1, 0, 0);
        cyc(8'hE4, 1, 0, 0);
        cyc(8'h55, 1, 0, 0);
        cyc(8'h66, 1, 0, 0);
        cyc(8'h77, 1, 0, 0);
        chk_word("rs.pre", 32'hE4E3E2E1, 4'hF);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rs.valid", 32'(out_valid), 32'd0);
        chk("rs.word", out_word, 32'h0);
        chk("rs.keep", 32'(out_keep), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc(8'h10, 1, 0, 1);
        cyc(8'h20, 1, 0, 1);
        cyc(8'h30, 1, 0, 1);
        chk("rs.no_early", 32'(out_valid), 32'd0);
        cyc(8'h40, 1, 0, 1);
        chk_word("rs.clean", 32'h40302010, 4'hF);
        cyc(8'h00, 0, 0, 1);
        chk("rs.once", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
